// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-requester memory arbiter.
//   - FSM state encoding (2-bit): IDLE=0, ACCESS=1, WAIT=2, DONE=3
//   - default data/address widths
//   - rr_pick(): 2-way round-robin selection rule
package mem_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // A sole requester always wins; on a tie the requester that did not win
  // last time is chosen. With no request the result is irrelevant.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = last_grant;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester handshakes and memory port A.
//   r0_*/r1_*  : requester request/we/addr/wdata in, ack/rdata out
//   mem_*      : synchronous RAM port A (addr/wdata/we out, rdata in)
//   busy, gnt  : arbiter status
// Modports:
//   slave  - the arbiter side (mem_arbiter)
//   master - the requester/memory environment side
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_ack;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_ack;
  logic [DATA_WIDTH-1:0] r1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  gnt;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy, gnt
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, gnt
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin pick with its last-grant register.
//   clk, rst : clock, synchronous active-high reset (last_grant -> 1)
//   en       : a grant is being taken this cycle; updates last_grant
//   req      : {r1_req, r0_req}
//   pick     : selected requester index (combinational)
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       pick
);

  logic last_grant;

  // Resetting to 1 makes the first tie after reset go to requester 0.
  assign pick = rr_pick(req, last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto port A of a synchronous RAM.
//   clk  : single clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave (requester handshakes, RAM port A, busy/gnt)
// Each access runs IDLE -> ACCESS -> WAIT -> DONE -> IDLE. The request
// fields are captured at the grant edge, so later changes on the requester
// side do not disturb the access in flight. All outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
)(
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t            state;
  logic [1:0]            req_vec;
  logic                  grant_en;
  logic                  pick;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  lat_we;
  logic                  gnt_q;
  logic                  busy_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_q;

  assign req_vec  = {bus.r1_req, bus.r0_req};
  assign grant_en = (state == IDLE) && (|req_vec);

  rr_arbiter2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .en   (grant_en),
    .req  (req_vec),
    .pick (pick)
  );

  always_comb begin
    sel_we    = bus.r0_we;
    sel_addr  = bus.r0_addr;
    sel_wdata = bus.r0_wdata;
    if (pick) begin
      sel_we    = bus.r1_we;
      sel_addr  = bus.r1_addr;
      sel_wdata = bus.r1_wdata;
    end
  end

  // mem_addr/mem_wdata double as the latched request fields; only the
  // read/write flag needs a separate copy because mem_we drops after ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            lat_we      <= sel_we;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            gnt_q       <= pick;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          // RAM data registered on the ACCESS->WAIT edge is valid now.
          if (!lat_we) begin
            if (gnt_q) begin
              rdata1_q <= bus.mem_rdata;
            end else begin
              rdata0_q <= bus.mem_rdata;
            end
          end
          ack0_q <= ~gnt_q;
          ack1_q <= gnt_q;
          state  <= DONE;
        end
        DONE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.r0_ack    = ack0_q;
  assign bus.r1_ack    = ack1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;
  assign bus.gnt       = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  function automatic logic [15:0] init_val(input int unsigned a);
    if (a == 16) return 16'h1234;
    return 16'((a * 40503) ^ 23130);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM on port A: 64 words, low address bits only.
  logic [DW-1:0] ram [0:63];
  bit ram_init = 0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] = init_val(i);
      ram_init = 1;
    end
    bus.mem_rdata <= ram[bus.mem_addr[5:0]];
    if (bus.mem_we) ram[bus.mem_addr[5:0]] = bus.mem_wdata;
  end

  // Reference model: a transaction timeline. m_rem counts the cycles left in
  // the current access (0 = free); memory content is a shadow array.
  int            m_rem = 0;
  logic          m_last, m_gnt, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd0, m_rd1;
  logic [DW-1:0] shadow [0:63];
  bit            m_valid = 0;
  bit            sh_init = 0;

  always @(posedge clk) begin
    int w;
    if (!sh_init) begin
      for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
      sh_init = 1;
    end
    if (rst) begin
      m_rem = 0; m_last = 1; m_gnt = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
      m_valid = 1;
    end else if (m_rem == 0) begin
      if (bus.r0_req || bus.r1_req) begin
        if (bus.r0_req && bus.r1_req) w = m_last ? 0 : 1;
        else w = bus.r1_req ? 1 : 0;
        m_gnt   = (w == 1);
        m_last  = m_gnt;
        m_we    = m_gnt ? bus.r1_we : bus.r0_we;
        m_addr  = m_gnt ? bus.r1_addr : bus.r0_addr;
        m_wdata = m_gnt ? bus.r1_wdata : bus.r0_wdata;
        m_rem   = 3;
      end
    end else begin
      if (m_rem == 3 && m_we) shadow[m_addr[5:0]] = m_wdata;
      if (m_rem == 2 && !m_we) begin
        if (m_gnt) m_rd1 = shadow[m_addr[5:0]];
        else       m_rd0 = shadow[m_addr[5:0]];
      end
      m_rem--;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy",     bus.busy,   m_rem != 0);
      check("gnt",      bus.gnt,    m_gnt);
      check("r0_ack",   bus.r0_ack, (m_rem == 1) && !m_gnt);
      check("r1_ack",   bus.r1_ack, (m_rem == 1) && m_gnt);
      check("mem_we",   bus.mem_we, (m_rem == 3) && m_we);
      check("r0_rdata", bus.r0_rdata, m_rd0);
      check("r1_rdata", bus.r1_rdata, m_rd1);
      if (m_rem != 0) begin
        check("mem_addr",  bus.mem_addr,  m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic drop_reqs();
    bus.r0_req = 0;
    bus.r1_req = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    drop_reqs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic set_r0(input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.r0_req = 1; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic set_r1(input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.r1_req = 1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  // Waits (bounded) for an ack; reports who, negedges waited, mem_we cycles.
  task automatic wait_ack(output int who, output int lat, output int we_cnt);
    who = -1; lat = 0; we_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.mem_we) we_cnt++;
      if (bus.r0_ack || bus.r1_ack) begin
        who = bus.r1_ack ? 1 : 0;
        lat = i;
        break;
      end
    end
    if (who < 0) begin
      checks++; fails++;
      $display("FAIL ack_timeout actual=none required=ack t=%0t", $time);
    end
  endtask

  task automatic rnd_fields(input int r);
    logic [15:0] a, d;
    logic we;
    a = 16'($urandom); d = 16'($urandom); we = 1'($urandom);
    if (r == 0) begin bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d; end
    else        begin bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d; end
  endtask

  typedef struct {
    logic        q0, q1;
    logic        we0, we1;
    logic [15:0] a0, a1, d0, d1;
    int          exp_gnt;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vt [10];

  initial begin
    int who, lat, wec;
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0;

    vt[0] = '{1, 1, 0, 0, 16'h0030, 16'h0040, 16'h0, 16'h0, 0, 3, 0};
    vt[1] = '{1, 1, 0, 1, 16'h0031, 16'h0041, 16'h0, 16'hA001, 1, 3, 1};
    vt[2] = '{1, 1, 1, 0, 16'h8032, 16'h0041, 16'h5002, 16'h0, 0, 3, 1};
    vt[3] = '{1, 0, 0, 0, 16'h0032, 16'h0, 16'h0, 16'h0, 0, 3, 0};
    vt[4] = '{1, 0, 0, 0, 16'h0041, 16'h0, 16'h0, 16'h0, 0, 3, 0};
    vt[5] = '{0, 1, 0, 0, 16'h0, 16'hFF32, 16'h0, 16'h0, 1, 3, 0};
    vt[6] = '{1, 1, 0, 0, 16'h0033, 16'h0034, 16'h0, 16'h0, 0, 3, 0};
    vt[7] = '{0, 1, 1, 1, 16'h0, 16'h0035, 16'h0, 16'h7777, 1, 3, 1};
    vt[8] = '{1, 1, 0, 0, 16'h0035, 16'h0036, 16'h0, 16'h0, 0, 3, 0};
    vt[9] = '{1, 1, 0, 0, 16'h0037, 16'h0035, 16'h0, 16'h0, 1, 3, 0};

    // Reset values
    do_reset();
    check("rst_busy",   bus.busy, 0);
    check("rst_gnt",    bus.gnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_addr",   bus.mem_addr, 0);
    check("rst_wdata",  bus.mem_wdata, 0);
    check("rst_rdata0", bus.r0_rdata, 0);
    check("rst_rdata1", bus.r1_rdata, 0);

    // Single read of 0x0010
    set_r0(0, 16'h0010, 16'h0);
    wait_ack(who, lat, wec);
    check("rd_who", who, 0);
    check("rd_lat", lat, 3);
    check("rd_data", bus.r0_rdata, 16'h1234);
    drop_reqs(); @(negedge clk);

    // Write then read by r1
    set_r1(1, 16'h0020, 16'hBEEF);
    wait_ack(who, lat, wec);
    check("wr_who", who, 1);
    check("wr_we_cycles", wec, 1);
    drop_reqs(); @(negedge clk);
    set_r1(0, 16'h0020, 16'h0);
    wait_ack(who, lat, wec);
    check("rdbk_we_cycles", wec, 0);
    check("rdbk_data", bus.r1_rdata, 16'hBEEF);
    check("rdbk_other", bus.r0_rdata, 16'h1234);
    drop_reqs(); @(negedge clk);

    // Address change after grant does not affect the access
    set_r0(0, 16'h0011, 16'h0);
    wait_ack(who, lat, wec);
    check("pre_data", bus.r0_rdata, init_val(17));
    drop_reqs(); @(negedge clk);
    set_r0(0, 16'h0010, 16'h0);
    @(negedge clk);
    bus.r0_addr = 16'h0011;
    bus.r0_we = 1;
    wait_ack(who, lat, wec);
    check("midflight_lat", lat, 2);
    check("midflight_data", bus.r0_rdata, 16'h1234);
    drop_reqs(); @(negedge clk);

    // Tie after reset, loser served 4 cycles later, next tie to r0
    do_reset();
    set_r0(0, 16'h0010, 16'h0);
    set_r1(0, 16'h0020, 16'h0);
    wait_ack(who, lat, wec);
    check("tie_first", who, 0);
    check("tie_first_lat", lat, 3);
    bus.r0_req = 0;
    wait_ack(who, lat, wec);
    check("tie_second", who, 1);
    check("tie_second_lat", lat, 4);
    drop_reqs(); @(negedge clk);
    set_r0(0, 16'h0001, 16'h0);
    set_r1(0, 16'h0002, 16'h0);
    wait_ack(who, lat, wec);
    check("tie_next", who, 0);
    drop_reqs(); @(negedge clk);

    // Arbitration table, starting from reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.r0_we = vt[i].we0; bus.r0_addr = vt[i].a0; bus.r0_wdata = vt[i].d0;
      bus.r1_we = vt[i].we1; bus.r1_addr = vt[i].a1; bus.r1_wdata = vt[i].d1;
      bus.r0_req = vt[i].q0; bus.r1_req = vt[i].q1;
      wait_ack(who, lat, wec);
      check($sformatf("tbl%0d_who", i), who, vt[i].exp_gnt);
      check($sformatf("tbl%0d_gnt", i), bus.gnt, vt[i].exp_gnt);
      check($sformatf("tbl%0d_lat", i), lat, vt[i].exp_lat);
      check($sformatf("tbl%0d_we", i), wec, vt[i].exp_we);
      drop_reqs(); @(negedge clk);
    end

    // Both continuously requesting: grants alternate
    do_reset();
    set_r0(0, 16'h0003, 16'h0);
    set_r1(0, 16'h0004, 16'h0);
    for (int k = 0; k < 8; k++) begin
      wait_ack(who, lat, wec);
      check($sformatf("alt%0d_who", k), who, k % 2);
      check($sformatf("alt%0d_lat", k), lat, (k == 0) ? 3 : 4);
    end
    drop_reqs(); @(negedge clk);

    // Reset during WAIT aborts the access
    do_reset();
    set_r0(0, 16'h0010, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drop_reqs();
    check("abort_busy", bus.busy, 0);
    check("abort_we", bus.mem_we, 0);
    check("abort_rdata", bus.r0_rdata, 0);
    who = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.r0_ack || bus.r1_ack) who++;
    end
    check("abort_no_ack", who, 0);
    set_r0(0, 16'h0010, 16'h0);
    set_r1(0, 16'h0011, 16'h0);
    wait_ack(who, lat, wec);
    check("abort_after_who", who, 0);
    check("abort_after_lat", lat, 3);
    check("abort_after_data", bus.r0_rdata, 16'h1234);
    drop_reqs(); @(negedge clk);

    // Randomised traffic against the model
    rnd_fields(0); rnd_fields(1);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rst) rst = 0;
      else if ($urandom_range(0, 249) == 0) rst = 1;
      if (bus.r0_req) begin
        if (bus.r0_ack) begin
          if ($urandom_range(0, 3) != 0) bus.r0_req = 0;
          else rnd_fields(0);
        end else if ($urandom_range(0, 7) == 0) rnd_fields(0);
      end else if ($urandom_range(0, 2) == 0) begin
        bus.r0_req = 1; rnd_fields(0);
      end
      if (bus.r1_req) begin
        if (bus.r1_ack) begin
          if ($urandom_range(0, 3) != 0) bus.r1_req = 0;
          else rnd_fields(1);
        end else if ($urandom_range(0, 7) == 0) rnd_fields(1);
      end else if ($urandom_range(0, 2) == 0) begin
        bus.r1_req = 1; rnd_fields(1);
      end
    end
    rst = 0;
    drop_reqs();
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
